// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, defaults and vector helpers for the keypad encoder
// Contents: FSM state enum, default parameter values, one-hot check and index encoder.
package keypad_pkg;

  // Widest key vector the helper functions accept.
  localparam int MAX_KEYS  = 32;
  localparam int KEY_IDX_W = 5;

  localparam int DEF_N_KEYS          = 10;
  localparam int DEF_CODE_W          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 500;
  localparam int DEF_REPEAT_PERIOD   = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_MULTI,
    ST_RELEASE
  } kp_state_t;

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input logic [MAX_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Index of the lowest set bit; callers only use it on one-hot vectors.
  function automatic logic [KEY_IDX_W-1:0] key_index(input logic [MAX_KEYS-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync_debounce.sv
// rtl/keypad_sync_debounce.sv - two-flop synchroniser plus stability counter for the key lines
// Ports: clk, reset (async, active-high), clear (sync flush of all state), numpad (raw lines),
//        stable_vec (last accepted debounced vector), stable_valid (one-cycle pulse on a new stable_vec).
module keypad_sync_debounce
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [N_KEYS-1:0] numpad,
  output logic [N_KEYS-1:0] stable_vec,
  output logic              stable_valid
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync_vec;
  logic [N_KEYS-1:0] prev_vec;
  logic [CNT_W-1:0]  cnt;

  // clear flushes the synchroniser too, so a key held across clear needs the full latency again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= '0;
      sync_vec     <= '0;
      prev_vec     <= '0;
      cnt          <= '0;
      stable_vec   <= '0;
      stable_valid <= 1'b0;
    end else if (clear) begin
      sync1        <= '0;
      sync_vec     <= '0;
      prev_vec     <= '0;
      cnt          <= '0;
      stable_vec   <= '0;
      stable_valid <= 1'b0;
    end else begin
      sync1        <= numpad;
      sync_vec     <= sync1;
      prev_vec     <= sync_vec;
      stable_valid <= 1'b0;
      if (sync_vec != prev_vec) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
        // Only a vector that differs from the last accepted one is reported; a glitch that
        // settles back to the accepted vector stays invisible downstream.
        if (cnt == CNT_MAX - CNT_W'(1) && sync_vec != stable_vec) begin
          stable_vec   <= sync_vec;
          stable_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_debounce_encoder.sv
// rtl/keypad_debounce_encoder.sv - debounced keypad encoder with press strobe and multi-key flag
// Ports: clk, reset (async, active-high), enablen (active-low enable), numpad (raw key lines),
//        code (accepted key index), valid_datan (low while a single key is held),
//        key_strobe (one pulse per press/repeat), multi_key (high while several keys are held).
// Optional build macro: KEYPAD_AUTO_REPEAT_EN adds held-key auto-repeat strobes.
module keypad_debounce_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int CODE_W          = DEF_CODE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enablen,
  input  logic [N_KEYS-1:0] numpad,
  output logic [CODE_W-1:0] code,
  output logic              valid_datan,
  output logic              key_strobe,
  output logic              multi_key
);

  if ((1 << CODE_W) < N_KEYS || N_KEYS > MAX_KEYS || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("keypad_debounce_encoder: invalid N_KEYS/CODE_W/DEBOUNCE_CYCLES");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("keypad_debounce_encoder: repeat timing must be at least one cycle");
  end

  logic [N_KEYS-1:0] stable_vec;
  logic              stable_valid;
  logic              vec_one_hot;
  logic              vec_any;
  logic [CODE_W-1:0] vec_code;
  kp_state_t         state;

  keypad_sync_debounce #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk          (clk),
    .reset        (reset),
    .clear        (enablen),
    .numpad       (numpad),
    .stable_vec   (stable_vec),
    .stable_valid (stable_valid)
  );

  assign vec_one_hot = is_one_hot(MAX_KEYS'(stable_vec));
  assign vec_any     = |stable_vec;
  assign vec_code    = CODE_W'(key_index(MAX_KEYS'(stable_vec)));

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_done;  // first repeat already issued; later ones use REPEAT_PERIOD
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      code        <= '0;
      valid_datan <= 1'b1;
      key_strobe  <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_done    <= 1'b0;
`endif
    end else if (enablen) begin
      state       <= ST_IDLE;
      valid_datan <= 1'b1;
      key_strobe  <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_done    <= 1'b0;
`endif
    end else begin
      key_strobe <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      // Cleared every cycle unless PRESSED holds with no new debounced vector.
      rpt_cnt  <= '0;
      rpt_done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (stable_valid) begin
            if (vec_one_hot) begin
              state       <= ST_PRESSED;
              code        <= vec_code;
              key_strobe  <= 1'b1;
              valid_datan <= 1'b0;
            end else if (vec_any) begin
              state     <= ST_MULTI;
              multi_key <= 1'b1;
            end
          end
        end
        ST_PRESSED: begin
          if (stable_valid) begin
            if (!vec_any) begin
              state       <= ST_RELEASE;
              valid_datan <= 1'b1;
            end else if (vec_one_hot) begin
              // Direct swap to another single key counts as a fresh press.
              code       <= vec_code;
              key_strobe <= 1'b1;
            end else begin
              state       <= ST_MULTI;
              valid_datan <= 1'b1;
              multi_key   <= 1'b1;
            end
          end
`ifdef KEYPAD_AUTO_REPEAT_EN
          else begin
            if ((!rpt_done && rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) ||
                ( rpt_done && rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))) begin
              key_strobe <= 1'b1;
              rpt_cnt    <= '0;
              rpt_done   <= 1'b1;
            end else begin
              rpt_cnt  <= rpt_cnt + 1'b1;
              rpt_done <= rpt_done;
            end
          end
`endif
        end
        ST_MULTI: begin
          if (stable_valid && !vec_any) begin
            state     <= ST_RELEASE;
            multi_key <= 1'b0;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// tb/tb_keypad_debounce_encoder.sv - scoreboard bench for keypad_debounce_encoder
module tb_keypad_debounce_encoder;

  localparam int N_KEYS = 10;
  localparam int CODE_W = 4;
  localparam int DB     = 4;
  localparam int RD     = 20;
  localparam int RP     = 5;
  // Input driven at the negedge of cycle c -> strobe seen at the negedge of cycle c + LAT.
  localparam int LAT    = 3 + DB;

  logic              clk = 1'b0;
  logic              reset;
  logic              enablen;
  logic [N_KEYS-1:0] numpad;
  logic [CODE_W-1:0] code;
  logic              valid_datan;
  logic              key_strobe;
  logic              multi_key;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int code;
    int cyc;
  } exp_t;
  exp_t sb[$];

  keypad_debounce_encoder #(
    .N_KEYS          (N_KEYS),
    .CODE_W          (CODE_W),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enablen     (enablen),
    .numpad      (numpad),
    .code        (code),
    .valid_datan (valid_datan),
    .key_strobe  (key_strobe),
    .multi_key   (multi_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected press.
  always @(negedge clk) begin
    exp_t e;
    if (key_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'(key_strobe), 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_code", 32'(code), 32'(e.code));
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drive(input logic [N_KEYS-1:0] v, input int exp_code);
    numpad = v;
    if (exp_code >= 0) sb.push_back('{exp_code, cyc + LAT});
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int t0;
    reset   = 1'b1;
    enablen = 1'b1;
    numpad  = '0;
    idle(3);
    check("rst_code",   32'(code),        32'd0);
    check("rst_valid",  32'(valid_datan), 32'd1);
    check("rst_strobe", 32'(key_strobe),  32'd0);
    check("rst_multi",  32'(multi_key),   32'd0);
    reset   = 1'b0;
    enablen = 1'b0;
    idle(10);

    // Clean press of key 4, then release: latency of both edges.
    t = cyc;
    drive(10'b0000010000, 4);
    until_cyc(t + LAT - 1);
    check("press_valid_early", 32'(valid_datan), 32'd1);
    until_cyc(t + LAT);
    check("press_valid", 32'(valid_datan), 32'd0);
    idle(4);
    t = cyc;
    drive('0, -1);
    until_cyc(t + LAT - 1);
    check("release_valid_early", 32'(valid_datan), 32'd0);
    until_cyc(t + LAT);
    check("release_valid", 32'(valid_datan), 32'd1);
    idle(4);

    // Key 9 bouncing in 2-cycle bursts, then held.
    for (int i = 0; i < 3; i++) begin
      drive(10'h200, -1);
      idle(2);
      drive('0, -1);
      idle(2);
    end
    t = cyc;
    drive(10'h200, 9);
    until_cyc(t + LAT + 2);
    check("glitch_code",  32'(code),        32'd9);
    check("glitch_valid", 32'(valid_datan), 32'd0);

    // Swap straight to key 5 without releasing.
    t = cyc;
    drive(10'h020, 5);
    until_cyc(t + LAT + 2);
    check("swap_code",  32'(code),        32'd5);
    check("swap_valid", 32'(valid_datan), 32'd0);
    drive('0, -1);
    idle(LAT + 3);

    // Two keys together from idle.
    t = cyc;
    drive(10'b0000000011, -1);
    until_cyc(t + LAT - 1);
    check("multi_early", 32'(multi_key), 32'd0);
    until_cyc(t + LAT);
    check("multi_set",   32'(multi_key),   32'd1);
    check("multi_valid", 32'(valid_datan), 32'd1);
    check("multi_code",  32'(code),        32'd5);
    idle(3);
    t = cyc;
    drive('0, -1);
    until_cyc(t + LAT - 1);
    check("multi_hold", 32'(multi_key), 32'd1);
    until_cyc(t + LAT);
    check("multi_clear", 32'(multi_key), 32'd0);
    idle(3);

    // Key 2 accepted, then key 8 joins.
    drive(10'h004, 2);
    idle(LAT + 2);
    t = cyc;
    drive(10'h104, -1);
    until_cyc(t + LAT);
    check("pm_valid", 32'(valid_datan), 32'd1);
    check("pm_multi", 32'(multi_key),   32'd1);
    drive('0, -1);
    idle(LAT + 3);
    check("pm_release", 32'(multi_key), 32'd0);

    // Disabled with key 0 held, then enabled.
    enablen = 1'b1;
    drive(10'h001, -1);
    idle(15);
    check("dis_valid", 32'(valid_datan), 32'd1);
    check("dis_multi", 32'(multi_key),   32'd0);
    check("dis_code",  32'(code),        32'd2);
    t = cyc;
    enablen = 1'b0;
    sb.push_back('{0, t + LAT});
    until_cyc(t + LAT + 1);
    check("en_code",  32'(code),        32'd0);
    check("en_valid", 32'(valid_datan), 32'd0);
    drive('0, -1);
    idle(LAT + 3);

    // Reset while key 7 is held.
    drive(10'h080, 7);
    idle(LAT + 3);
    reset = 1'b1;
    #1;
    check("midrst_code",  32'(code),        32'd0);
    check("midrst_valid", 32'(valid_datan), 32'd1);
    check("midrst_multi", 32'(multi_key),   32'd0);
    @(negedge clk);
    idle(2);
    t = cyc;
    reset = 1'b0;
    sb.push_back('{7, t + LAT});
    until_cyc(t + LAT + 1);
    check("postrst_code",  32'(code),        32'd7);
    check("postrst_valid", 32'(valid_datan), 32'd0);
    drive('0, -1);
    idle(LAT + 3);

`ifdef KEYPAD_AUTO_REPEAT_EN
    // Held key 3: strobes at t0, t0+RD, then every RP; released before the next one.
    t  = cyc;
    t0 = t + LAT;
    drive(10'h008, 3);
    sb.push_back('{3, t0 + RD});
    sb.push_back('{3, t0 + RD + RP});
    sb.push_back('{3, t0 + RD + 2 * RP});
    until_cyc(t0 + RD + RP - 1);
    drive('0, -1);
    idle(LAT + 10);
    check("rpt_valid", 32'(valid_datan), 32'd1);
`else
    t0 = 0;
`endif

    idle(5);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
